// File: rtl/imem_loader.sv
// Streams a byte-serial load into instruction memory: 8-byte base address, 2-byte length, then payload.
// Writes are range-checked before any byte is written; a running XOR checksum covers written bytes.
module imem_loader #(
  parameter int unsigned MEM_SIZE = 1025
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_wEn,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done,
  output logic        load_err,
  output logic [7:0]  checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [15:0] k_q, k_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cs_q, cs_d;

  logic        busy_w;
  logic [15:0] len_full;
  logic [64:0] end_addr;

  assign busy_w   = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_DATA);
  assign len_full = {in_data, len_q[15:8]};
  // One bit wider than the address so a huge base cannot wrap into range.
  assign end_addr = {1'b0, base_q} + {49'd0, len_full};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    len_d   = len_q;
    k_d     = k_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cs_d    = cs_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            k_d     = 16'd0;
            cs_d    = 8'd0;
          end
        end
        S_ADDR: begin
          if (in_valid) begin
            base_d = {in_data, base_q[63:8]};
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = S_LEN;
            end
          end
        end
        S_LEN: begin
          if (in_valid) begin
            len_d = len_full;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q[0]) begin
              cnt_d = 3'd0;
              if (end_addr > 65'(MEM_SIZE)) begin
                state_d = S_ERR;
              end else if (len_full == 16'd0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (in_valid) begin
            wen_d  = 1'b1;
            addr_d = base_q + {48'd0, k_q};
            data_d = in_data;
            cs_d   = cs_q ^ in_data;
            k_d    = k_q + 16'd1;
            if (({1'b0, k_q} + 17'd1) == {1'b0, len_q}) begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      base_q  <= 64'd0;
      len_q   <= 16'd0;
      k_q     <= 16'd0;
      wen_q   <= 1'b0;
      addr_q  <= 64'd0;
      data_q  <= 8'd0;
      cs_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      len_q   <= len_d;
      k_q     <= k_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
    end
  end

  assign in_ready = busy_w;
  assign busy     = busy_w;
  assign done     = (state_q == S_DONE);
  assign load_err = (state_q == S_ERR);
  assign mem_wEn  = wen_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign checksum = cs_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus queues expected writes and status checks,
// a negedge monitor pops and compares them against the DUT.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wEn;
  logic [63:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        load_err;
  logic [7:0]  checksum;

  imem_loader #(.MEM_SIZE(1025)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_wEn  (mem_wEn),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .load_err (load_err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;

  // kind 0: status flags/checksum, 1: all expected writes seen, 2: every output zero
  typedef struct {
    int          kind;
    string       name;
    logic [11:0] st;
    bit          cs_chk;
  } chk_t;

  wr_t  wr_q[$];
  chk_t chk_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Flag nibbles for {in_ready, busy, done, load_err}
  localparam logic [3:0] F_BUSY = 4'b1100;
  localparam logic [3:0] F_DONE = 4'b0010;
  localparam logic [3:0] F_ERR  = 4'b0001;
  localparam logic [3:0] F_IDLE = 4'b0000;

  initial begin : monitor
    wr_t         w;
    chk_t        c;
    logic [11:0] act;
    logic [11:0] req;
    forever begin
      @(negedge clk);
      if (mem_wEn === 1'b1) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: got addr=%0h data=%0h, required no write", mem_addr, mem_data);
        end else begin
          w = wr_q.pop_front();
          if (mem_addr !== w.a || mem_data !== w.d) begin
            miscompares++;
            $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h", mem_addr, mem_data, w.a, w.d);
          end else begin
            $display("pass write addr=%0h data=%0h", mem_addr, mem_data);
          end
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        vectors++;
        if (c.kind == 1) begin
          if (wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: got %0d writes outstanding, required 0", c.name, wr_q.size());
          end else begin
            $display("pass %s", c.name);
          end
        end else if (c.kind == 2) begin
          if ({mem_wEn, mem_addr, mem_data, in_ready, busy, done, load_err, checksum} !== 85'd0) begin
            miscompares++;
            $display("FAIL %s: got wEn=%b addr=%0h data=%0h rdy=%b busy=%b done=%b err=%b cs=%0h, required all 0",
                     c.name, mem_wEn, mem_addr, mem_data, in_ready, busy, done, load_err, checksum);
          end else begin
            $display("pass %s", c.name);
          end
        end else begin
          act = {in_ready, busy, done, load_err, checksum};
          req = c.st;
          if (!c.cs_chk) begin
            act[7:0] = 8'd0;
            req[7:0] = 8'd0;
          end
          if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got rdy/busy/done/err=%b cs=%0h, required %b cs=%0h",
                     c.name, act[11:8], act[7:0], req[11:8], req[7:0]);
          end else begin
            $display("pass %s", c.name);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] f, input logic [7:0] cs, input bit cs_chk);
    chk_t c;
    c.kind = 0; c.name = nm; c.st = {f, cs}; c.cs_chk = cs_chk;
    chk_q.push_back(c);
  endtask

  task automatic chk_kind(input string nm, input int kind);
    chk_t c;
    c.kind = kind; c.name = nm; c.st = 12'd0; c.cs_chk = 1'b0;
    chk_q.push_back(c);
  endtask

  task automatic send(input logic [7:0] b, input bit exp_wr, input logic [63:0] a);
    wr_t w;
    if (exp_wr) begin
      w.a = a; w.d = b;
      wr_q.push_back(w);
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic hdr(input logic [63:0] base, input logic [15:0] len, input bit start_mid);
    for (int i = 0; i < 8; i++) begin
      if (start_mid && i == 4) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send(base[8*i +: 8], 1'b0, 64'd0);
    end
    send(len[7:0], 1'b0, 64'd0);
    send(len[15:8], 1'b0, 64'd0);
  endtask

  initial begin : stim
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    #1;
    chk_kind("reset_state", 2);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic two-byte load
    start_load();
    chk("started", F_BUSY, 8'h00, 1'b1);
    hdr(64'h14, 16'd2, 1'b0);
    send(8'h60, 1'b1, 64'd20);
    send(8'hBA, 1'b1, 64'd21);
    chk("basic_done", F_DONE, 8'hDA, 1'b1);
    send(8'h55, 1'b0, 64'd0);
    chk("ignored_in_done", F_DONE, 8'hDA, 1'b1);
    chk_kind("basic_drain", 1);

    // Range checks around MEM_SIZE
    start_load();
    hdr(64'h400, 16'd2, 1'b0);
    chk("range_400_2", F_ERR, 8'h00, 1'b1);
    send(8'h99, 1'b0, 64'd0);
    chk("ignored_in_err", F_ERR, 8'h00, 1'b1);
    start_load();
    hdr(64'h3FF, 16'd3, 1'b0);
    chk("range_3ff_3", F_ERR, 8'h00, 1'b1);
    start_load();
    hdr(64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 1'b0);
    chk("range_nowrap", F_ERR, 8'h00, 1'b1);
    start_load();
    hdr(64'h400, 16'd1, 1'b0);
    send(8'h77, 1'b1, 64'h400);
    chk("range_400_1", F_DONE, 8'h77, 1'b1);
    start_load();
    hdr(64'h3FF, 16'd2, 1'b0);
    send(8'h01, 1'b1, 64'h3FF);
    send(8'h02, 1'b1, 64'h400);
    chk("range_3ff_2", F_DONE, 8'h03, 1'b1);
    chk_kind("range_drain", 1);

    // Zero length
    start_load();
    hdr(64'h0, 16'd0, 1'b0);
    chk("len_zero", F_DONE, 8'h00, 1'b1);
    chk_kind("len_zero_drain", 1);

    // Abort with the third data byte
    start_load();
    hdr(64'h100, 16'd4, 1'b0);
    send(8'h11, 1'b1, 64'h100);
    send(8'h22, 1'b1, 64'h101);
    abort = 1'b1;
    send(8'h33, 1'b0, 64'd0);
    abort = 1'b0;
    chk("abort_idle", F_IDLE, 8'h33, 1'b1);
    chk_kind("abort_drain", 1);

    // Start while busy ignored, then gapped data
    start_load();
    hdr(64'h200, 16'd3, 1'b1);
    send(8'hA1, 1'b1, 64'h200);
    tick();
    send(8'hB2, 1'b1, 64'h201);
    tick();
    send(8'hC3, 1'b1, 64'h202);
    chk("gapped_done", F_DONE, 8'hD0, 1'b1);
    chk_kind("gapped_drain", 1);

    // Asynchronous reset while a write is being presented
    start_load();
    hdr(64'h10, 16'd3, 1'b0);
    send(8'hD1, 1'b1, 64'h10);
    in_valid = 1'b1;
    in_data  = 8'hE2;
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    chk_kind("async_reset", 2);
    tick();
    rst_n = 1'b1;
    chk("after_reset", F_IDLE, 8'h00, 1'b1);
    tick();
    start_load();
    hdr(64'h30, 16'd2, 1'b0);
    send(8'h5A, 1'b1, 64'h30);
    send(8'hA5, 1'b1, 64'h31);
    chk("reload_done", F_DONE, 8'hFF, 1'b1);

    // Abort beats start from DONE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start", F_IDLE, 8'h00, 1'b0);
    send(8'h44, 1'b0, 64'd0);
    chk("ignored_in_idle", F_IDLE, 8'h00, 1'b0);
    chk_kind("final_drain", 1);

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
